// File: rtl/tlc_phase_sequencer.sv
// N-phase traffic-light sequencer: green -> yellow -> all-red per approach, with peak/off-peak
// green times and demand-based skipping. Optional gap extension under `define TLC_GAP_EXT_EN.
module tlc_phase_sequencer #(
    parameter int unsigned NUM_PHASES    = 6,
    parameter int unsigned TW            = 8,
    parameter int unsigned GREEN_PEAK    = 20,
    parameter int unsigned GREEN_OFFPEAK = 10,
    parameter int unsigned YELLOW_T      = 3,
    parameter int unsigned ALLRED_T      = 1,
    parameter int unsigned EXT_T         = 5,
    parameter int unsigned MAX_EXT       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          peak,
    input  logic [NUM_PHASES-1:0]         sensor,
    output logic [2*NUM_PHASES-1:0]       tl,
    output logic [TW-1:0]                 timer,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [NUM_PHASES-1:0]         demand
);
    localparam int unsigned PW = $clog2(NUM_PHASES);

    if (NUM_PHASES < 2 || NUM_PHASES > 16 || GREEN_PEAK == 0 || GREEN_OFFPEAK == 0 ||
        YELLOW_T == 0 || ALLRED_T == 0 || EXT_T == 0 || MAX_EXT == 0) begin : g_bad_params
        $error("tlc_phase_sequencer: illegal parameter values");
    end

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [NUM_PHASES-1:0]   demand_q, demand_d;
    logic [2*NUM_PHASES-1:0] tl_q, tl_d;
    logic [PW-1:0]           phase_inc;
    logic [PW-1:0]           phase_next;
    logic [PW-1:0]           cand_idx;
    logic                    found;

`ifdef TLC_GAP_EXT_EN
    localparam int unsigned EW = $clog2(MAX_EXT + 1);
    logic [EW-1:0] ext_q, ext_d;
`endif

    assign phase_inc = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

    // Off-peak search starts one past the current phase and wraps back to it last.
    always_comb begin
        phase_next = phase_inc;
        found      = 1'b0;
        cand_idx   = '0;
        if (!peak) begin
            for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
                cand_idx = PW'((32'(phase_q) + k) % NUM_PHASES);
                if (!found && demand_q[cand_idx]) begin
                    found      = 1'b1;
                    phase_next = cand_idx;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        phase_d  = phase_q;
        demand_d = demand_q | sensor;
`ifdef TLC_GAP_EXT_EN
        ext_d    = ext_q;
`endif
        if (state_q == S_GREEN) begin
            demand_d[phase_q] = demand_q[phase_q];
        end
        if (tick) begin
            if (timer_q > TW'(1)) begin
                timer_d = timer_q - TW'(1);
            end else begin
                unique case (state_q)
                    S_ALLRED: begin
                        state_d           = S_GREEN;
                        phase_d           = phase_next;
                        timer_d           = peak ? TW'(GREEN_PEAK) : TW'(GREEN_OFFPEAK);
                        demand_d[phase_d] = 1'b0;
`ifdef TLC_GAP_EXT_EN
                        ext_d             = '0;
`endif
                    end
                    S_GREEN: begin
`ifdef TLC_GAP_EXT_EN
                        if (sensor[phase_q] && (ext_q < EW'(MAX_EXT))) begin
                            timer_d = TW'(EXT_T);
                            ext_d   = ext_q + EW'(1);
                        end else begin
                            state_d = S_YELLOW;
                            timer_d = TW'(YELLOW_T);
                        end
`else
                        state_d = S_YELLOW;
                        timer_d = TW'(YELLOW_T);
`endif
                    end
                    S_YELLOW: begin
                        state_d = S_ALLRED;
                        timer_d = TW'(ALLRED_T);
                    end
                    default: begin
                        state_d = S_ALLRED;
                        timer_d = TW'(ALLRED_T);
                    end
                endcase
            end
        end
    end

    // Lights are decoded from the next state so tl stays aligned with state/phase registers.
    always_comb begin
        tl_d = '0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (phase_d == PW'(i)) begin
                if (state_d == S_GREEN) begin
                    tl_d[2*i +: 2] = 2'd2;
                end else if (state_d == S_YELLOW) begin
                    tl_d[2*i +: 2] = 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_ALLRED;
            timer_q  <= TW'(ALLRED_T);
            phase_q  <= PW'(NUM_PHASES - 1);
            demand_q <= '0;
            tl_q     <= '0;
`ifdef TLC_GAP_EXT_EN
            ext_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            demand_q <= demand_d;
            tl_q     <= tl_d;
`ifdef TLC_GAP_EXT_EN
            ext_q    <= ext_d;
`endif
        end
    end

    assign tl     = tl_q;
    assign timer  = timer_q;
    assign phase  = phase_q;
    assign demand = demand_q;

endmodule
